// File: rtl/wb_write_queue.sv
// Writeback queue: buffers register-file writes in a circular FIFO, drains the
// head entry whenever the write port is free, and forwards pending data to the
// decode stage so reads see the youngest queued value for a register.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   enq_valid/enq_ready             producer handshake
//   enq_addr/enq_data/enq_pc        queued write {register, value, trace PC}
//   wb_stall                        register-file write port busy this cycle
//   RegWE/A3/RWD/WPC                register-file write port (combinational from head)
//   A1rs/A2rt                       decode read addresses to check
//   fwd_hit_rs/rt, fwd_rs/rt        pending-write match and youngest matching data
//   count                           number of valid entries
module wb_write_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [4:0]               enq_addr,
    input  logic [31:0]              enq_data,
    input  logic [31:0]              enq_pc,
    input  logic                     wb_stall,
    output logic                     RegWE,
    output logic [4:0]               A3,
    output logic [31:0]              RWD,
    output logic [31:0]              WPC,
    input  logic [4:0]               A1rs,
    input  logic [4:0]               A2rt,
    output logic                     fwd_hit_rs,
    output logic                     fwd_hit_rt,
    output logic [31:0]              fwd_rs,
    output logic [31:0]              fwd_rt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               not_empty;
    logic               enq_fire;
    logic               drain;

    assign not_empty = (count_q != '0);
    // Address-0 handshakes complete but never create an entry.
    assign enq_fire  = enq_valid && (count_q != CNT_W'(DEPTH)) && (enq_addr != 5'd0);
    assign drain     = not_empty && !wb_stall;

    // Pointer, occupancy and storage next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (enq_fire) begin
            mem_d[tail_q] = '{addr: enq_addr, data: enq_data, pc: enq_pc};
            tail_d        = tail_q + PTR_W'(1);
        end
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq_fire && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq_fire && drain) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; reset wins over enqueue and drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never cleared; the head/count window decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Write port and handshake; reset forces the idle view immediately.
    always_comb begin
        enq_ready = reset || (count_q != CNT_W'(DEPTH));
        RegWE     = !reset && drain;
        A3        = '0;
        RWD       = '0;
        WPC       = '0;
        if (!reset && not_empty) begin
            A3  = mem_q[head_q].addr;
            RWD = mem_q[head_q].data;
            WPC = mem_q[head_q].pc;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        fwd_hit_rs = 1'b0;
        fwd_hit_rt = 1'b0;
        fwd_rs     = '0;
        fwd_rt     = '0;
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_q + PTR_W'(k);
                if (CNT_W'(k) < count_q) begin
                    if ((A1rs != 5'd0) && (mem_q[idx].addr == A1rs)) begin
                        fwd_hit_rs = 1'b1;
                        fwd_rs     = mem_q[idx].data;
                    end
                    if ((A2rt != 5'd0) && (mem_q[idx].addr == A2rt)) begin
                        fwd_hit_rt = 1'b1;
                        fwd_rt     = mem_q[idx].data;
                    end
                end
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based reference model.
module tb_wb_write_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic        enq_ready;
    logic [4:0]  enq_addr;
    logic [31:0] enq_data;
    logic [31:0] enq_pc;
    logic        wb_stall;
    logic        RegWE;
    logic [4:0]  A3;
    logic [31:0] RWD;
    logic [31:0] WPC;
    logic [4:0]  A1rs;
    logic [4:0]  A2rt;
    logic        fwd_hit_rs;
    logic        fwd_hit_rt;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [2:0]  count;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data), .enq_pc(enq_pc),
        .wb_stall(wb_stall),
        .RegWE(RegWE), .A3(A3), .RWD(RWD), .WPC(WPC),
        .A1rs(A1rs), .A2rt(A2rt),
        .fwd_hit_rs(fwd_hit_rs), .fwd_hit_rt(fwd_hit_rt),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t mq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic cyc(input logic rst, input logic ev, input logic [4:0] ad,
                       input logic [31:0] dd, input logic [31:0] pc,
                       input logic st, input logic [4:0] r1, input logic [4:0] r2);
        logic        e_rdy, e_we, h1, h2;
        logic [4:0]  e_a3;
        logic [31:0] e_d, e_p, f1, f2;
        int          sz;
        @(negedge clk);
        reset = rst; enq_valid = ev; enq_addr = ad; enq_data = dd; enq_pc = pc;
        wb_stall = st; A1rs = r1; A2rt = r2;
        #1;
        sz    = mq.size();
        e_rdy = rst || (sz != DEPTH);
        e_we  = !rst && (sz != 0) && !st;
        e_a3  = '0; e_d = '0; e_p = '0;
        if (!rst && sz != 0) begin
            e_a3 = mq[0].a; e_d = mq[0].d; e_p = mq[0].p;
        end
        h1 = 1'b0; h2 = 1'b0; f1 = '0; f2 = '0;
        if (!rst) begin
            foreach (mq[i]) begin
                if (r1 != 0 && mq[i].a == r1) begin h1 = 1'b1; f1 = mq[i].d; end
                if (r2 != 0 && mq[i].a == r2) begin h2 = 1'b1; f2 = mq[i].d; end
            end
        end
        check("enq_ready", 64'(enq_ready), 64'(e_rdy));
        check("RegWE", 64'(RegWE), 64'(e_we));
        check("A3", 64'(A3), 64'(e_a3));
        check("RWD", 64'(RWD), 64'(e_d));
        check("WPC", 64'(WPC), 64'(e_p));
        check("count", 64'(count), 64'(sz));
        check("fwd_hit_rs", 64'(fwd_hit_rs), 64'(h1));
        check("fwd_hit_rt", 64'(fwd_hit_rt), 64'(h2));
        check("fwd_rs", 64'(fwd_rs), 64'(f1));
        check("fwd_rt", 64'(fwd_rt), 64'(f2));
        // Model update for the coming edge.
        if (rst) begin
            mq.delete();
        end else begin
            if (e_we) begin
                void'(mq.pop_front());
                n_writes++;
            end
            if (ev && (sz != DEPTH) && ad != 0) mq.push_back('{a: ad, d: dd, p: pc});
        end
    endtask

    task automatic idle(input logic st);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, st, 5'd0, 5'd0);
    endtask

    initial begin
        reset = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_pc = '0;
        wb_stall = 1'b0; A1rs = '0; A2rt = '0;
        repeat (2) @(posedge clk);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd3, 5'd4);

        // Single write.
        cyc(1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd5, 5'd0);
        idle(1'b0);
        idle(1'b0);

        // Fill while stalled, hold a fifth request, then release.
        for (int i = 1; i <= 4; i++)
            cyc(1'b0, 1'b1, 5'(i), 32'(i * 16), 32'h4000 + 32'(i * 4), 1'b1, 5'd2, 5'd4);
        cyc(1'b0, 1'b1, 5'd6, 32'h66, 32'h4100, 1'b1, 5'd0, 5'd1);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 5'd6, 32'h66, 32'h4100, 1'b0, 5'd6, 5'd3);
        repeat (5) idle(1'b0);

        // Youngest-match forwarding.
        cyc(1'b0, 1'b1, 5'd8, 32'hA, 32'h5000, 1'b1, 5'd8, 5'd9);
        cyc(1'b0, 1'b1, 5'd8, 32'hB, 32'h5004, 1'b1, 5'd8, 5'd9);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8, 5'd9);
        repeat (3) idle(1'b0);

        // Register 0 writes are swallowed.
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFF, 32'h6000, 1'b0, 5'd0, 5'd0);
        idle(1'b0);

        // Wrap-around with steady occupancy of one.
        cyc(1'b0, 1'b1, 5'd10, 32'h100, 32'h7000, 1'b1, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b1, 5'(11 + i), 32'h200 + 32'(i), 32'h7100 + 32'(i * 4), 1'b0, 5'(11 + i), 5'(10 + i));
        repeat (2) idle(1'b0);

        // Reset with pending entries, then a fresh single write.
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 5'(20 + i), 32'hDEAD0 + 32'(i), 32'h8000, 1'b1, 5'd20, 5'd21);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd20, 5'd21);
        idle(1'b0);
        cyc(1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd20, 5'd5);
        idle(1'b0);
        idle(1'b0);

        // Random traffic over a small address set to provoke matches.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 65),
                5'($urandom_range(0, 7)),
                $urandom(), $urandom(),
                ($urandom_range(0, 99) < 40),
                5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)));
        end

        if (n_writes == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL writes_seen got=0 want>0");
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of queued writeback entries (power of two, 2..16).
REQ-002 The block SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have enq_valid  input  1  writeback request from producer stage.
REQ-005 The block SHALL have enq_ready  output  1  queue can accept a request this cycle.
REQ-006 The block SHALL have enq_addr  input  5  destination register number.
REQ-007 The block SHALL have enq_data  input  32  value to write.
REQ-008 The block SHALL have enq_pc  input  32  PC of producing instruction (trace only).
REQ-009 The block SHALL have wb_stall  input  1  register-file write port unavailable this cycle.
REQ-010 The block SHALL have RegWE  output  1  register-file write enable.
REQ-011 The block SHALL have A3  output  5  register-file write address.
REQ-012 The block SHALL have RWD  output  32  register-file write data.
REQ-013 The block SHALL have WPC  output  32  PC accompanying the write.
REQ-014 The block SHALL have A1rs, A2rt  input  5 each  decode-stage read addresses to check against pending writes.
REQ-015 The block SHALL have fwd_hit_rs, fwd_hit_rt  output  1 each  a pending entry targets that address.
REQ-016 The block SHALL have fwd_rs, fwd_rt  output  32 each  data of youngest matching pending entry, else 0.
REQ-017 The block SHALL have count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 Storage SHALL be a circular FIFO: head/tail pointers wrap modulo DEPTH, separate occupancy counter 0..DEPTH.
REQ-019 enq_ready SHALL equal (count != DEPTH); no same-cycle full bypass.
REQ-020 Enqueue SHALL occur when enq_valid & enq_ready & enq_addr != 0; entry {addr,data,pc} written at tail, tail advances.
REQ-021 A handshake with enq_addr == 0 SHALL be accepted (enq_ready honoured) and discarded: no entry, count unchanged.
REQ-022 Drain SHALL occur when count != 0 & !wb_stall; head entry is consumed at that edge, head advances.
REQ-023 RegWE SHALL be combinational = (count != 0) & !wb_stall; A3/RWD/WPC = head entry fields when count != 0, else 0.
REQ-024 Latency SHALL be one cycle minimum: an entry enqueued at edge N appears on RegWE/A3 in cycle after N, and is written at edge N+1 if not stalled.
REQ-025 Simultaneous enqueue and drain SHALL leave count unchanged; both pointers advance.
REQ-026 Enqueue SHALL be blocked only when full; drain SHALL proceed when full, so enq_ready rises the cycle after a drain from full.
REQ-027 Order SHALL be strict FIFO: writes reach the register file in acceptance order, including repeated writes to one address.
REQ-028 Forwarding SHALL compare A1rs/A2rt combinationally against all valid entries, including the head being drained this cycle.
REQ-029 With multiple matches, fwd data SHALL come from the youngest (closest to tail) entry.
REQ-030 Address 0 SHALL never produce fwd_hit; fwd_hit = 0 implies fwd data = 0.
REQ-031 Entries not valid (outside head..tail window) SHALL never match, regardless of stale contents.
REQ-032 count SHALL be registered and equal number of valid entries after each edge.

Reset
REQ-033 When reset is high at an edge, head, tail, count SHALL become 0 and all entries invalid; reset has priority over enqueue and drain.
REQ-034 During and after reset: RegWE=0, A3=0, RWD=0, WPC=0, fwd_hit_*=0, fwd_*=0, count=0, enq_ready=1.
REQ-035 Reset mid-operation SHALL discard all pending writes; none reach the register file.
REQ-036 Entry storage contents need not be cleared; validity alone governs outputs.

Verification
REQ-037 Single write: enq {addr=5,data=0x1234,pc=0x3000} -> next cycle RegWE=1,A3=5,RWD=0x1234,WPC=0x3000; following cycle RegWE=0,count=0.
REQ-038 Fill: wb_stall=1, enqueue addrs 1..4 -> count=4, enq_ready=0, 5th request held; release stall -> writes 1,2,3,4 on consecutive cycles, 5th accepted the cycle after first drain.
REQ-039 Forward: wb_stall=1, enqueue (8,0xA) then (8,0xB), A1rs=8, A2rt=9 -> fwd_hit_rs=1,fwd_rs=0xB, fwd_hit_rt=0,fwd_rt=0.
REQ-040 Zero register: enq addr=0 data=0xFFFF -> accepted, count stays 0, RegWE never asserted; A1rs=0 -> fwd_hit_rs=0.
REQ-041 Wrap-around: 10 back-to-back enqueue+drain cycles with DEPTH=4 -> writes in order, count constant at 1, no loss/duplication.
REQ-042 Reset mid-queue: 3 entries pending, wb_stall=1, reset one cycle -> count=0, RegWE=0, no listed write ever appears; fresh enqueue then behaves as REQ-037.
